// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-requester arbiter and sequencer in front of the 32-bit data RAM.
//   Port A is the CPU load/store unit and port B is the debug/DMA loader.
//   One access is granted at a time and runs IDLE -> ISSUE -> ACK, which is
//   three cycles. The RAM port is driven from registers. Read data is captured
//   into the winner's rdata. The winner then gets a one-cycle ack.
//   Misaligned accesses and accesses with mode 11 never touch the RAM. They
//   complete with err set.
// Ports
//   clk, clr_n                      clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_mode/a_wdata port A request fields, held until a_ack
//   a_ack/a_err/a_rdata             port A completion pulse, error, load data
//   b_*                             port B, same meaning as a_*
//   ram_addr/ram_wdata/ram_mode     registered RAM address, data and size
//   ram_we/ram_sel                  registered RAM write enable and select
//   ram_rdata                       combinational RAM read data
//   busy                            high while in ISSUE or ACK
//   owner                           0 = A, 1 = B; current or last granted port
module mem_port_arbiter #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int PRIO_FIXED = 0
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [1:0]        a_mode,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic              a_err,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [1:0]        b_mode,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic              b_err,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic [1:0]        ram_mode,
   output logic              ram_we,
   output logic              ram_sel,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              owner
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_ACK   = 2'd2
   } state_t;

   // Flags mode 11, and half or word accesses that are not naturally aligned.
   function automatic logic access_err(input logic [1:0] mode, input logic [1:0] lo);
      logic bad;
      case (mode)
         2'b00:   bad = 1'b0;
         2'b01:   bad = lo[0];
         2'b10:   bad = (lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   state_t              state_r, state_s;
   logic                grant_s, grant_b_s;
   logic                win_we_s, win_err_s;
   logic [ADDR_W-1:0]   win_addr_s;
   logic [1:0]          win_mode_s;
   logic [DATA_W-1:0]   win_wdata_s;

   logic [ADDR_W-1:0]   ram_addr_r;
   logic [DATA_W-1:0]   ram_wdata_r, a_rdata_r, b_rdata_r;
   logic [1:0]          ram_mode_r;
   logic                ram_we_r, ram_sel_r, busy_r, owner_r;
   logic                we_lat_r, err_lat_r;
   logic                a_ack_r, a_err_r, b_ack_r, b_err_r;

   // Next-state logic and selection of the winning request.
   always_comb begin
      state_s   = state_r;
      grant_s   = 1'b0;
      grant_b_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (a_req && b_req) begin
               grant_s = 1'b1;
               if (PRIO_FIXED != 0) begin
                  grant_b_s = 1'b0;
               end else begin
                  // On a tie, the port that did not win last time is granted.
                  grant_b_s = ~owner_r;
               end
            end else if (a_req) begin
               grant_s = 1'b1;
            end else if (b_req) begin
               grant_s   = 1'b1;
               grant_b_s = 1'b1;
            end else begin
               grant_s = 1'b0;
            end
            if (grant_s) begin
               state_s = ST_ISSUE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: state_s = ST_ACK;
         ST_ACK:   state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // Multiplexes the winner's request fields and checks them for errors.
   always_comb begin
      win_we_s    = grant_b_s ? b_we    : a_we;
      win_addr_s  = grant_b_s ? b_addr  : a_addr;
      win_mode_s  = grant_b_s ? b_mode  : a_mode;
      win_wdata_s = grant_b_s ? b_wdata : a_wdata;
      win_err_s   = access_err(win_mode_s, win_addr_s[1:0]);
   end

   // State register.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // RAM port, ack, err and rdata registers for each phase of an access.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         ram_addr_r  <= {ADDR_W{1'b0}};
         ram_wdata_r <= {DATA_W{1'b0}};
         ram_mode_r  <= 2'b10;
         ram_we_r    <= 1'b0;
         ram_sel_r   <= 1'b0;
         busy_r      <= 1'b0;
         owner_r     <= 1'b1;
         we_lat_r    <= 1'b0;
         err_lat_r   <= 1'b0;
         a_ack_r     <= 1'b0;
         a_err_r     <= 1'b0;
         a_rdata_r   <= {DATA_W{1'b0}};
         b_ack_r     <= 1'b0;
         b_err_r     <= 1'b0;
         b_rdata_r   <= {DATA_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_s) begin
                  ram_addr_r  <= win_addr_s;
                  ram_wdata_r <= win_wdata_s;
                  ram_mode_r  <= win_mode_s;
                  // A rejected access leaves the RAM deselected during ISSUE.
                  ram_sel_r   <= ~win_err_s;
                  ram_we_r    <= win_we_s & ~win_err_s;
                  we_lat_r    <= win_we_s;
                  err_lat_r   <= win_err_s;
                  owner_r     <= grant_b_s;
                  busy_r      <= 1'b1;
               end
            end
            ST_ISSUE: begin
               ram_sel_r <= 1'b0;
               ram_we_r  <= 1'b0;
               if (owner_r) begin
                  b_ack_r <= 1'b1;
                  b_err_r <= err_lat_r;
                  if (!we_lat_r && !err_lat_r) begin
                     b_rdata_r <= ram_rdata;
                  end
               end else begin
                  a_ack_r <= 1'b1;
                  a_err_r <= err_lat_r;
                  if (!we_lat_r && !err_lat_r) begin
                     a_rdata_r <= ram_rdata;
                  end
               end
            end
            ST_ACK: begin
               a_ack_r <= 1'b0;
               a_err_r <= 1'b0;
               b_ack_r <= 1'b0;
               b_err_r <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               ram_sel_r <= 1'b0;
               ram_we_r  <= 1'b0;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

   assign ram_addr  = ram_addr_r;
   assign ram_wdata = ram_wdata_r;
   assign ram_mode  = ram_mode_r;
   assign ram_we    = ram_we_r;
   assign ram_sel   = ram_sel_r;
   assign busy      = busy_r;
   assign owner     = owner_r;
   assign a_ack     = a_ack_r;
   assign a_err     = a_err_r;
   assign a_rdata   = a_rdata_r;
   assign b_ack     = b_ack_r;
   assign b_err     = b_err_r;
   assign b_rdata   = b_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. It contains a byte-addressed RAM model
//   with byte/half/word lanes and a combinational, zero-extended read.
//   A second instance with PRIO_FIXED=1 shares the request inputs. That
//   instance is used to check the fixed-priority grant order.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        clr_n = 1'b0;
   logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [11:0] a_addr = 12'h000, b_addr = 12'h000;
   logic [1:0]  a_mode = 2'b10, b_mode = 2'b10;
   logic [31:0] a_wdata = 32'h0, b_wdata = 32'h0;
   logic        a_ack, a_err, b_ack, b_err;
   logic [31:0] a_rdata, b_rdata;
   logic [11:0] ram_addr;
   logic [31:0] ram_wdata, ram_rdata;
   logic [1:0]  ram_mode;
   logic        ram_we, ram_sel, busy, owner;

   logic        f_a_ack, f_a_err, f_b_ack, f_b_err;
   logic [31:0] f_a_rdata, f_b_rdata, f_ram_wdata;
   logic [31:0] f_ram_rdata;
   logic [11:0] f_ram_addr;
   logic [1:0]  f_ram_mode;
   logic        f_ram_we, f_ram_sel, f_busy, f_owner;

   int checks_cnt = 0;
   int errors_cnt = 0;

   logic [7:0]  mem [0:4095];
   logic [11:0] ra1, ra2, ra3;

   assign f_ram_rdata = 32'h0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .PRIO_FIXED(0)) dut (
      .clk(clk), .clr_n(clr_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_mode(a_mode), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_mode(b_mode), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_mode(ram_mode),
      .ram_we(ram_we), .ram_sel(ram_sel), .ram_rdata(ram_rdata),
      .busy(busy), .owner(owner)
   );

   mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .PRIO_FIXED(1)) dut_fixed (
      .clk(clk), .clr_n(clr_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_mode(a_mode), .a_wdata(a_wdata),
      .a_ack(f_a_ack), .a_err(f_a_err), .a_rdata(f_a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_mode(b_mode), .b_wdata(b_wdata),
      .b_ack(f_b_ack), .b_err(f_b_err), .b_rdata(f_b_rdata),
      .ram_addr(f_ram_addr), .ram_wdata(f_ram_wdata), .ram_mode(f_ram_mode),
      .ram_we(f_ram_we), .ram_sel(f_ram_sel), .ram_rdata(f_ram_rdata),
      .busy(f_busy), .owner(f_owner)
   );

   assign ra1 = ram_addr + 12'd1;
   assign ra2 = ram_addr + 12'd2;
   assign ra3 = ram_addr + 12'd3;

   // RAM model read path: little-endian and zero-extended.
   always_comb begin
      case (ram_mode)
         2'b00:   ram_rdata = {24'h0, mem[ram_addr]};
         2'b01:   ram_rdata = {16'h0, mem[ra1], mem[ram_addr]};
         default: ram_rdata = {mem[ra3], mem[ra2], mem[ra1], mem[ram_addr]};
      endcase
   end

   // RAM model write path: right-aligned data is placed on the addressed lanes.
   always @(posedge clk) begin
      if (ram_sel && ram_we) begin
         case (ram_mode)
            2'b00: mem[ram_addr] <= ram_wdata[7:0];
            2'b01: begin
               mem[ram_addr] <= ram_wdata[7:0];
               mem[ra1]      <= ram_wdata[15:8];
            end
            2'b10: begin
               mem[ram_addr] <= ram_wdata[7:0];
               mem[ra1]      <= ram_wdata[15:8];
               mem[ra2]      <= ram_wdata[23:16];
               mem[ra3]      <= ram_wdata[31:24];
            end
            default: ;
         endcase
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      clr_n = 1'b1;
   endtask

   // One access on port A (pb=0) or port B (pb=1). The cycle in which req is
   // raised is cycle 1.
   task automatic access(input bit pb, input bit we, input logic [11:0] addr,
                         input logic [1:0] mode, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int ack_cyc,
                         output int busy_n, output int sel_n, output logic other_ack);
      @(negedge clk);
      if (pb) begin
         b_req = 1'b1; b_we = we; b_addr = addr; b_mode = mode; b_wdata = wd;
      end else begin
         a_req = 1'b1; a_we = we; a_addr = addr; a_mode = mode; a_wdata = wd;
      end
      ack_cyc = 0; busy_n = 0; sel_n = 0; other_ack = 1'b0; rd = 32'h0; er = 1'b0;
      for (int c = 2; c <= 10; c++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (ram_sel) sel_n++;
         other_ack = other_ack | (pb ? a_ack : b_ack);
         if (pb ? b_ack : a_ack) begin
            ack_cyc = c;
            rd = pb ? b_rdata : a_rdata;
            er = pb ? b_err : a_err;
            break;
         end
      end
      a_req = 1'b0;
      b_req = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er, oth;
      int          cyc, bn, sn, na, nb, nfa, nfb;
      logic [3:0]  order, forder;

      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

      // Reset values.
      @(negedge clk);
      check_eq("rst ram_sel", {31'h0, ram_sel}, 32'h0);
      check_eq("rst ram_we", {31'h0, ram_we}, 32'h0);
      check_eq("rst ram_addr", {20'h0, ram_addr}, 32'h0);
      check_eq("rst ram_wdata", ram_wdata, 32'h0);
      check_eq("rst ram_mode", {30'h0, ram_mode}, 32'h2);
      check_eq("rst busy", {31'h0, busy}, 32'h0);
      check_eq("rst owner", {31'h0, owner}, 32'h1);
      check_eq("rst acks", {30'h0, a_ack, b_ack}, 32'h0);
      check_eq("rst a_rdata", a_rdata, 32'h0);
      @(negedge clk);
      clr_n = 1'b1;

      // Word store, then word load.
      access(1'b0, 1'b1, 12'h010, 2'b10, 32'hDEADBEEF, rd, er, cyc, bn, sn, oth);
      check_eq("t1 st ack cycle", cyc, 32'd3);
      check_eq("t1 st err", {31'h0, er}, 32'h0);
      check_eq("t1 st busy cycles", bn, 32'd2);
      check_eq("t1 st sel cycles", sn, 32'd1);
      access(1'b0, 1'b0, 12'h010, 2'b10, 32'h0, rd, er, cyc, bn, sn, oth);
      check_eq("t1 ld ack cycle", cyc, 32'd3);
      check_eq("t1 ld rdata", rd, 32'hDEADBEEF);
      check_eq("t1 ld err", {31'h0, er}, 32'h0);

      // Byte store into lane 3, then word, byte and half loads.
      access(1'b0, 1'b1, 12'h013, 2'b00, 32'h0000005A, rd, er, cyc, bn, sn, oth);
      check_eq("t2 st ack cycle", cyc, 32'd3);
      access(1'b0, 1'b0, 12'h010, 2'b10, 32'h0, rd, er, cyc, bn, sn, oth);
      check_eq("t2 word rdata", rd, 32'h5AADBEEF);
      access(1'b0, 1'b0, 12'h013, 2'b00, 32'h0, rd, er, cyc, bn, sn, oth);
      check_eq("t2 byte rdata", rd, 32'h0000005A);
      access(1'b0, 1'b0, 12'h012, 2'b01, 32'h0, rd, er, cyc, bn, sn, oth);
      check_eq("t2 half rdata", rd, 32'h00005AAD);

      // Both ports hold req for 12 cycles after a reset.
      do_reset();
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b0; a_addr = 12'h010; a_mode = 2'b10;
      b_req = 1'b1; b_we = 1'b0; b_addr = 12'h013; b_mode = 2'b00;
      na = 0; nb = 0; nfa = 0; nfb = 0; order = 4'h0; forder = 4'h0;
      for (int c = 2; c <= 12; c++) begin
         @(negedge clk);
         if (a_ack || b_ack) begin
            if ((na + nb) < 4) order[na + nb] = b_ack;
            if (a_ack) na++; else nb++;
         end
         if (f_a_ack || f_b_ack) begin
            if ((nfa + nfb) < 4) forder[nfa + nfb] = f_b_ack;
            if (f_a_ack) nfa++; else nfb++;
         end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      check_eq("t3 rr grant count", na + nb, 32'd4);
      check_eq("t3 rr order", {28'h0, order}, 32'h0000000A);
      check_eq("t3 fixed grant count", nfa + nfb, 32'd4);
      check_eq("t3 fixed order", {28'h0, forder}, 32'h0);
      check_eq("t3 a_rdata", a_rdata, 32'h5AADBEEF);
      check_eq("t3 b_rdata", b_rdata, 32'h0000005A);

      // Misaligned word store, then a load of the old value, then mode 11.
      access(1'b0, 1'b1, 12'h012, 2'b10, 32'hCAFEF00D, rd, er, cyc, bn, sn, oth);
      check_eq("t4 misalign ack cycle", cyc, 32'd3);
      check_eq("t4 misalign err", {31'h0, er}, 32'h1);
      check_eq("t4 misalign sel", sn, 32'd0);
      access(1'b0, 1'b0, 12'h010, 2'b10, 32'h0, rd, er, cyc, bn, sn, oth);
      check_eq("t4 old value", rd, 32'h5AADBEEF);
      check_eq("t4 ld err", {31'h0, er}, 32'h0);
      access(1'b0, 1'b0, 12'h010, 2'b11, 32'h0, rd, er, cyc, bn, sn, oth);
      check_eq("t4 mode11 err", {31'h0, er}, 32'h1);
      check_eq("t4 mode11 sel", sn, 32'd0);
      check_eq("t4 rdata held on err", rd, 32'h5AADBEEF);
      access(1'b1, 1'b0, 12'h011, 2'b01, 32'h0, rd, er, cyc, bn, sn, oth);
      check_eq("t4 b half misalign err", {31'h0, er}, 32'h1);
      check_eq("t4 b rdata held", rd, 32'h0000005A);

      // Reset asserted during the ISSUE cycle of a store.
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b1; a_addr = 12'h010; a_mode = 2'b10; a_wdata = 32'h11223344;
      @(negedge clk);
      check_eq("t5 we in issue", {31'h0, ram_we}, 32'h1);
      clr_n = 1'b0;
      #1;
      check_eq("t5 we drops", {31'h0, ram_we}, 32'h0);
      check_eq("t5 sel drops", {31'h0, ram_sel}, 32'h0);
      a_req = 1'b0;
      @(negedge clk);
      check_eq("t5 no ack", {30'h0, a_ack, b_ack}, 32'h0);
      check_eq("t5 busy", {31'h0, busy}, 32'h0);
      check_eq("t5 owner", {31'h0, owner}, 32'h1);
      check_eq("t5 ram_mode", {30'h0, ram_mode}, 32'h2);
      check_eq("t5 ram_addr", {20'h0, ram_addr}, 32'h0);
      check_eq("t5 a_rdata", a_rdata, 32'h0);
      @(negedge clk);
      clr_n = 1'b1;

      // B load while A is idle. The RAM word must be unchanged.
      access(1'b1, 1'b0, 12'h010, 2'b10, 32'h0, rd, er, cyc, bn, sn, oth);
      check_eq("t6 b ack cycle", cyc, 32'd3);
      check_eq("t6 b rdata", rd, 32'h5AADBEEF);
      check_eq("t6 a_ack quiet", {31'h0, oth}, 32'h0);
      check_eq("t6 a_rdata quiet", a_rdata, 32'h0);
      check_eq("t6 busy cycles", bn, 32'd2);
      check_eq("t6 owner", {31'h0, owner}, 32'h1);
      access(1'b0, 1'b0, 12'h010, 2'b10, 32'h0, rd, er, cyc, bn, sn, oth);
      check_eq("t6 a rdata", rd, 32'h5AADBEEF);
      check_eq("t6 b_ack quiet", {31'h0, oth}, 32'h0);
      check_eq("t6 owner after a", {31'h0, owner}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
